// File: rtl/pipo_reg_pkg.sv
// Shared constants and types for the parallel-in, parallel-out register.
package pipo_reg_pkg;

  localparam int unsigned PipoWidth = 4;

  typedef logic [PipoWidth-1:0] pipo_word_t;

endpackage

// File: rtl/pipo_dff.sv
// Single-bit D flip-flop with synchronous active-high clear.
module pipo_dff (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= 1'b0;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipo_reg.sv
// Parallel-in, parallel-out register: loads d every edge, clear forces zero.
module pipo_reg
  import pipo_reg_pkg::*;
#(
  parameter int unsigned WIDTH = PipoWidth
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // One flop per bit; no cross-bit paths.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pipo_dff u_dff (
      .clk   (clk),
      .clear (clear),
      .d     (d[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_pipo_reg.sv
// Directed self-checking bench for pipo_reg at WIDTH 4 and WIDTH 8.
module tb_pipo_reg;
  import pipo_reg_pkg::*;

  logic       clk = 1'b0;
  logic       clear;
  pipo_word_t d;
  pipo_word_t q;
  logic       clear8;
  logic [7:0] d8;
  logic [7:0] q8;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pipo_reg u_dut (
    .clk   (clk),
    .clear (clear),
    .d     (d),
    .q     (q)
  );

  pipo_reg #(
    .WIDTH (8)
  ) u_dut8 (
    .clk   (clk),
    .clear (clear8),
    .d     (d8),
    .q     (q8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  pipo_word_t seq [4] = '{4'b0011, 4'b0111, 4'b1001, 4'b1111};

  initial begin
    clear  = 1'b1;
    d      = 4'b1111;
    clear8 = 1'b1;
    d8     = 8'hff;

    // Reset held for three edges with d all ones.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset%0d", i), {4'b0, q}, 8'h00);
    end
    check("reset8", q8, 8'h00);

    // Single load, observed before and after the edge.
    clear = 1'b0;
    d     = 4'b0001;
    #2;
    check("load_pre", {4'b0, q}, 8'h00);
    tick();
    check("load", {4'b0, q}, 8'h01);

    // Back-to-back words, one edge latency each.
    for (int i = 0; i < 4; i++) begin
      d = seq[i];
      #2;
      check($sformatf("seq_hold%0d", i), {4'b0, q}, (i == 0) ? 8'h01 : {4'b0, seq[i-1]});
      tick();
      check($sformatf("seq%0d", i), {4'b0, q}, {4'b0, seq[i]});
    end

    // Mid-stream clear with d held at all ones.
    clear = 1'b1;
    tick();
    check("mid_clear", {4'b0, q}, 8'h00);
    clear = 1'b0;
    tick();
    check("mid_resume", {4'b0, q}, 8'h0f);

    // Glitch on d between edges; only the edge value matters.
    d = 4'b0101;
    #2;
    d = 4'b1010;
    #1;
    check("glitch_hold", {4'b0, q}, 8'h0f);
    #1;
    d = 4'b0101;
    tick();
    check("glitch", {4'b0, q}, 8'h05);

    // Eight-bit instance.
    clear8 = 1'b0;
    d8     = 8'b1010_0101;
    tick();
    check("w8_load", q8, 8'b1010_0101);
    clear8 = 1'b1;
    tick();
    check("w8_clear", q8, 8'h00);
    check("w4_unaffected", {4'b0, q}, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
